multi_string_comparator: RTL

Parametrised successor to the single-pattern string comparator. It scans a streamed packet payload for up to NUM_PATTERNS programmable flagged strings, including matches that straddle word boundaries. Per-pattern hits are sticky until cleared. The payload passes through unmodified with a fixed latency, so downstream sniffer logic sees the data and the match result together.

---
 rtl/string_match_pkg.sv | 27 ++
 rtl/multi_string_comparator_if.sv | 37 +++
 rtl/pattern_match_unit.sv | 75 +++++++
 rtl/multi_string_comparator.sv | 114 +++++++++++
 4 files changed

// File: rtl/string_match_pkg.sv
// Shared types and helpers for the multi-pattern stream comparator.
// Holds the byte type, the pass-through latency formula and a priority encoder.
package string_match_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // One stage per word of pattern history, plus compare and flag registration.
  function automatic int calc_lat(input int max_len, input int bpw);
    return (max_len - 1 + bpw - 1) / bpw + 2;
  endfunction

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lowest_set(input logic [31:0] vec);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/multi_string_comparator_if.sv
// Stream, pattern-programming and match-result signals of the comparator.
// The design side takes the slave modport; the driver side takes master.
interface multi_string_comparator_if #(
  parameter int BYTES_PER_WORD = 4,
  parameter int MAX_LEN        = 17,
  parameter int NUM_PATTERNS   = 4
) ();
  import string_match_pkg::*;

  localparam int SEL_W  = clog2_min1(NUM_PATTERNS);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;

  logic                      clear;
  logic                      data_valid;
  logic [WORD_W-1:0]         data_in;
  logic                      pat_wr_en;
  logic [SEL_W-1:0]          pat_sel;
  logic [BYTE_W*MAX_LEN-1:0] pat_data;
  logic [LEN_W-1:0]          pat_len;
  logic [WORD_W-1:0]         data_out;
  logic                      data_out_valid;
  logic [NUM_PATTERNS-1:0]   match_vec;
  logic                      match;
  logic [SEL_W-1:0]          match_id;

  modport master (
    output clear, data_valid, data_in, pat_wr_en, pat_sel, pat_data, pat_len,
    input  data_out, data_out_valid, match_vec, match, match_id
  );

  modport slave (
    input  clear, data_valid, data_in, pat_wr_en, pat_sel, pat_data, pat_len,
    output data_out, data_out_valid, match_vec, match, match_id
  );

endinterface

// File: rtl/pattern_match_unit.sv
// One pattern slot: stored pattern/length, window compare at every end
// position of the newest word, and the sticky hit flag.
module pattern_match_unit
  import string_match_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int MAX_LEN        = 17
) (
  input  logic                                          clk,
  input  logic                                          n_rst,
  input  logic                                          i_wr_en,
  input  logic [BYTE_W*MAX_LEN-1:0]                     i_pat_data,
  input  logic [$clog2(MAX_LEN+1)-1:0]                  i_pat_len,
  input  logic [BYTE_W*(MAX_LEN+BYTES_PER_WORD-1)-1:0]  i_win,
  input  logic [$clog2(MAX_LEN+BYTES_PER_WORD)-1:0]     i_fill,
  input  logic                                          i_new_word,
  input  logic                                          i_clear,
  output logic                                          o_flag,
  output logic                                          o_flag_nxt
);

  localparam int WIN   = MAX_LEN + BYTES_PER_WORD - 1;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic [BYTE_W*MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]          r_len;
  logic                      r_flag;
  logic                      w_hit;
  logic                      w_eq;
  byte_t                     w_win_b [WIN];
  byte_t                     w_pat_b [MAX_LEN];

  always_comb begin
    for (int i = 0; i < WIN; i++) w_win_b[i] = i_win[BYTE_W*(WIN-1-i) +: BYTE_W];
    for (int k = 0; k < MAX_LEN; k++) w_pat_b[k] = r_pat[BYTE_W*(MAX_LEN-1-k) +: BYTE_W];
  end

  // Window byte 0 is the oldest; the new word sits in bytes MAX_LEN-1 .. WIN-1.
  // A length-l hit ending at new-word byte j needs BYTES_PER_WORD-1-j+l fresh bytes.
  always_comb begin
    w_hit = 1'b0;
    w_eq  = 1'b0;
    for (int j = 0; j < BYTES_PER_WORD; j++) begin
      for (int l = 1; l <= MAX_LEN; l++) begin
        w_eq = 1'b1;
        for (int k = 0; k < l; k++) begin
          if (w_win_b[MAX_LEN - l + j + k] != w_pat_b[k]) w_eq = 1'b0;
        end
        if (w_eq && (r_len == LEN_W'(l)) &&
            (32'(i_fill) >= 32'(BYTES_PER_WORD - 1 - j + l))) begin
          w_hit = 1'b1;
        end
      end
    end
    if (!i_new_word) w_hit = 1'b0;
  end

  assign o_flag_nxt = i_clear ? w_hit : (r_flag | w_hit);
  assign o_flag     = r_flag;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_pat  <= '0;
      r_len  <= '0;
      r_flag <= 1'b0;
    end else begin
      r_flag <= o_flag_nxt;
      if (i_wr_en) begin
        r_pat <= i_pat_data;
        r_len <= (i_pat_len > LEN_W'(MAX_LEN)) ? '0 : i_pat_len;
      end
    end
  end

endmodule

// File: rtl/multi_string_comparator.sv
// Streams payload words past NUM_PATTERNS pattern slots, flagging sticky hits
// (including word-straddling ones) while passing the data through with LAT delay.
module multi_string_comparator
  import string_match_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int MAX_LEN        = 17,
  parameter int NUM_PATTERNS   = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  multi_string_comparator_if.slave  bus
);

  localparam int LAT    = calc_lat(MAX_LEN, BYTES_PER_WORD);
  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int WIN    = MAX_LEN + BYTES_PER_WORD - 1;
  localparam int HIST   = MAX_LEN - 1;
  localparam int FILL_W = $clog2(WIN + 1);
  localparam int SEL_W  = clog2_min1(NUM_PATTERNS);

  logic [WORD_W-1:0]       r_pipe_data [LAT];
  logic [LAT-1:0]          r_pipe_vld;
  logic [BYTE_W*HIST-1:0]  r_hist;
  logic [FILL_W-1:0]       r_fill;
  logic                    r_match;
  logic [SEL_W-1:0]        r_match_id;
  logic [BYTE_W*WIN-1:0]   w_win;
  logic [FILL_W:0]         w_fill_sum;
  logic [FILL_W-1:0]       w_fill_eff;
  logic [NUM_PATTERNS-1:0] w_wr_sel;
  logic [NUM_PATTERNS-1:0] w_flag;
  logic [NUM_PATTERNS-1:0] w_flag_nxt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < LAT; i++) r_pipe_data[i] <= '0;
      r_pipe_vld <= '0;
    end else begin
      r_pipe_data[0] <= bus.data_in;
      for (int i = 1; i < LAT; i++) r_pipe_data[i] <= r_pipe_data[i-1];
      r_pipe_vld <= {r_pipe_vld[LAT-2:0], bus.data_valid};
    end
  end

  assign w_win = {r_hist, bus.data_in};

  // Fill count as seen by the word arriving now; a clear restarts it at this word.
  always_comb begin
    w_fill_sum = {1'b0, r_fill} + (FILL_W+1)'(BYTES_PER_WORD);
    w_fill_eff = w_fill_sum[FILL_W-1:0];
    if (bus.clear) begin
      w_fill_eff = FILL_W'(BYTES_PER_WORD);
    end else if (w_fill_sum > (FILL_W+1)'(WIN)) begin
      w_fill_eff = FILL_W'(WIN);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (bus.data_valid) begin
      r_hist <= w_win[BYTE_W*HIST-1:0];
      r_fill <= w_fill_eff;
    end else if (bus.clear) begin
      r_fill <= '0;
    end
  end

  always_comb begin
    w_wr_sel = '0;
    for (int i = 0; i < NUM_PATTERNS; i++) begin
      w_wr_sel[i] = bus.pat_wr_en && (bus.pat_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_PATTERNS; g++) begin : g_slot
    pattern_match_unit #(
      .BYTES_PER_WORD (BYTES_PER_WORD),
      .MAX_LEN        (MAX_LEN)
    ) u_pmu (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_wr_en    (w_wr_sel[g]),
      .i_pat_data (bus.pat_data),
      .i_pat_len  (bus.pat_len),
      .i_win      (w_win),
      .i_fill     (w_fill_eff),
      .i_new_word (bus.data_valid),
      .i_clear    (bus.clear),
      .o_flag     (w_flag[g]),
      .o_flag_nxt (w_flag_nxt[g])
    );
  end

  // Summary outputs are registered from the same next-state as the flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_match    <= 1'b0;
      r_match_id <= '0;
    end else begin
      r_match    <= |w_flag_nxt;
      r_match_id <= SEL_W'(lowest_set(32'(w_flag_nxt)));
    end
  end

  assign bus.data_out       = r_pipe_data[LAT-1];
  assign bus.data_out_valid = r_pipe_vld[LAT-1];
  assign bus.match_vec      = w_flag;
  assign bus.match          = r_match;
  assign bus.match_id       = r_match_id;

endmodule
